// File: rtl/rfphoenix_vec_wb.sv
// Vector writeback buffer: merges ALU results with the prior target per lane and queues them for the RF write port.
// Optional operand bypass of the head entry is enabled by defining RFPHOENIX_VEC_WB_BYPASS_EN.
module rfphoenix_vec_wb #(
  parameter int NLANES = 16,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NLANES*32-1:0]   res_i,
  input  logic [NLANES*32-1:0]   t_i,
  input  logic [NLANES-1:0]      mask_i,
  input  logic                   zm_i,
  input  logic                   scalar_i,
  input  logic [5:0]             rd_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [5:0]             wb_rd_o,
  output logic [NLANES*32-1:0]   wb_data_o,
  output logic [NLANES-1:0]      wb_we_o,
  output logic [31:0]            wb_count_o,
  output logic                   byp_valid_o,
  output logic [5:0]             byp_rd_o,
  output logic [NLANES*32-1:0]   byp_data_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DW    = NLANES * 32;

  // Entry storage is deliberately left unreset; only the pointers qualify it.
  logic [5:0]        rd_mem   [DEPTH];
  logic [DW-1:0]     data_mem [DEPTH];
  logic [NLANES-1:0] we_mem   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [31:0]       wb_count_reg;
  logic [DW-1:0]     merged_next;
  logic [NLANES-1:0] we_next;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready_o = (count_reg < CNT_W'(DEPTH));
  assign wb_valid_o = (count_reg != '0);
  assign push       = in_valid_i & in_ready_o;
  assign pop        = wb_valid_o & wb_ready_i;

  // A scalar target keeps only lane 0 and ignores the mask entirely.
  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      if (gi == 0) begin : g_lane0
        assign merged_next[31:0] = (scalar_i || mask_i[0]) ? res_i[31:0]
                                 : (zm_i ? 32'h0 : t_i[31:0]);
      end else begin : g_laneN
        assign merged_next[gi*32 +: 32] = scalar_i ? 32'h0
                                        : mask_i[gi] ? res_i[gi*32 +: 32]
                                        : (zm_i ? 32'h0 : t_i[gi*32 +: 32]);
      end
    end
  endgenerate

  assign we_next = scalar_i ? NLANES'(1) : '1;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= rd_i;
      data_mem[wr_ptr_reg] <= merged_next;
      we_mem[wr_ptr_reg]   <= we_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      wb_count_reg <= '0;
    end else if (flush_i) begin
      // A flush wins over any same-cycle handshake, so a pop here is not counted.
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop) begin
        rd_ptr_reg   <= ptr_inc(rd_ptr_reg);
        wb_count_reg <= wb_count_reg + 32'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign wb_rd_o    = rd_mem[rd_ptr_reg];
  assign wb_data_o  = data_mem[rd_ptr_reg];
  assign wb_we_o    = we_mem[rd_ptr_reg];
  assign wb_count_o = wb_count_reg;

`ifdef RFPHOENIX_VEC_WB_BYPASS_EN
  assign byp_valid_o = wb_valid_o;
  assign byp_rd_o    = rd_mem[rd_ptr_reg];
  assign byp_data_o  = data_mem[rd_ptr_reg];
`else
  assign byp_valid_o = 1'b0;
  assign byp_rd_o    = 6'd0;
  assign byp_data_o  = '0;
`endif
endmodule

// File: tb/tb_rfphoenix_vec_wb.sv
// Directed self-checking bench for rfphoenix_vec_wb (NLANES=16, DEPTH=2) with hand-computed expectations.
module tb_rfphoenix_vec_wb;
  localparam int NLANES = 16;
  localparam int DW     = NLANES * 32;
`ifdef RFPHOENIX_VEC_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DW-1:0]     res_i = '0;
  logic [DW-1:0]     t_i = '0;
  logic [NLANES-1:0] mask_i = '0;
  logic              zm_i = 1'b0;
  logic              scalar_i = 1'b0;
  logic [5:0]        rd_i = '0;
  logic              wb_valid_o;
  logic              wb_ready_i = 1'b0;
  logic [5:0]        wb_rd_o;
  logic [DW-1:0]     wb_data_o;
  logic [NLANES-1:0] wb_we_o;
  logic [31:0]       wb_count_o;
  logic              byp_valid_o;
  logic [5:0]        byp_rd_o;
  logic [DW-1:0]     byp_data_o;

  int checks = 0;
  int failures = 0;

  rfphoenix_vec_wb #(.NLANES(NLANES), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .res_i(res_i), .t_i(t_i), .mask_i(mask_i), .zm_i(zm_i),
    .scalar_i(scalar_i), .rd_i(rd_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_count_o(wb_count_o),
    .byp_valid_o(byp_valid_o), .byp_rd_o(byp_rd_o), .byp_data_o(byp_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] rd, input logic [DW-1:0] res,
                       input logic [DW-1:0] t, input logic [NLANES-1:0] mask,
                       input logic zm, input logic sc);
    in_valid_i = v; rd_i = rd; res_i = res; t_i = t; mask_i = mask; zm_i = zm; scalar_i = sc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_a, exp_b, exp_s;
    exp_a = {{8{32'h22222222}}, {8{32'h11111111}}};
    exp_b = {{8{32'h00000000}}, {8{32'h11111111}}};
    exp_s = {{15{32'h00000000}}, 32'h0000ABCD};

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    check("rst_wb_valid", DW'(wb_valid_o), DW'(0));
    check("rst_in_ready", DW'(in_ready_o), DW'(1));
    check("rst_byp_valid", DW'(byp_valid_o), DW'(0));
    check("rst_wb_count", DW'(wb_count_o), DW'(0));

    // Masked merge keeping the prior target, then discarded by flush
    drive(1'b1, 6'd5, {NLANES{32'h11111111}}, {NLANES{32'h22222222}}, 16'h00FF, 1'b0, 1'b0);
    step();
    in_valid_i = 1'b0;
    check("merge_valid", DW'(wb_valid_o), DW'(1));
    check("merge_data", wb_data_o, exp_a);
    check("merge_we", DW'(wb_we_o), DW'(16'hFFFF));
    check("merge_rd", DW'(wb_rd_o), DW'(5));
    check("merge_byp_valid", DW'(byp_valid_o), DW'(BYP));
    check("merge_byp_data", byp_data_o, BYP ? exp_a : DW'(0));
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush1_valid", DW'(wb_valid_o), DW'(0));
    check("flush1_count", DW'(wb_count_o), DW'(0));

    // Zeroing merge, popped once
    drive(1'b1, 6'd6, {NLANES{32'h11111111}}, {NLANES{32'h22222222}}, 16'h00FF, 1'b1, 1'b0);
    step();
    in_valid_i = 1'b0;
    check("zm_data", wb_data_o, exp_b);
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    check("zm_pop_valid", DW'(wb_valid_o), DW'(0));
    check("zm_pop_count", DW'(wb_count_o), DW'(1));

    // Scalar target
    drive(1'b1, 6'd9, {{15{32'h33333333}}, 32'h0000ABCD}, {NLANES{32'h22222222}}, 16'h0000, 1'b0, 1'b1);
    step();
    in_valid_i = 1'b0;
    check("scalar_we", DW'(wb_we_o), DW'(16'h0001));
    check("scalar_data", wb_data_o, exp_s);
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    check("scalar_count", DW'(wb_count_o), DW'(2));

    // Backpressure: three results against a two-entry buffer
    drive(1'b1, 6'd1, {NLANES{32'h01010101}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    check("bp_ready_after1", DW'(in_ready_o), DW'(1));
    drive(1'b1, 6'd2, {NLANES{32'h02020202}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    check("bp_ready_after2", DW'(in_ready_o), DW'(0));
    drive(1'b1, 6'd3, {NLANES{32'h03030303}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    check("bp_ready_held", DW'(in_ready_o), DW'(0));
    check("bp_head_stable_rd", DW'(wb_rd_o), DW'(1));
    check("bp_head_stable_data", wb_data_o, {NLANES{32'h01010101}});
    wb_ready_i = 1'b1;
    step();
    check("bp_pop2_rd", DW'(wb_rd_o), DW'(2));
    check("bp_ready_after_pop", DW'(in_ready_o), DW'(1));
    step();
    in_valid_i = 1'b0;
    check("bp_pop3_rd", DW'(wb_rd_o), DW'(3));
    check("bp_pop3_data", wb_data_o, {NLANES{32'h03030303}});
    check("bp_pop3_valid", DW'(wb_valid_o), DW'(1));
    step();
    wb_ready_i = 1'b0;
    check("bp_drained", DW'(wb_valid_o), DW'(0));
    check("bp_count", DW'(wb_count_o), DW'(5));

    // Flush while full with a push offered
    drive(1'b1, 6'd7, {NLANES{32'h07070707}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    rd_i = 6'd8;
    step();
    check("flush_full_ready", DW'(in_ready_o), DW'(0));
    flush_i = 1'b1;
    rd_i = 6'd10;
    step();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("flush_valid", DW'(wb_valid_o), DW'(0));
    check("flush_ready", DW'(in_ready_o), DW'(1));
    check("flush_count", DW'(wb_count_o), DW'(5));

    // Flush coinciding with a pop is not counted
    drive(1'b1, 6'd11, {NLANES{32'h0B0B0B0B}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    in_valid_i = 1'b0;
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    check("flushpop_valid", DW'(wb_valid_o), DW'(0));
    check("flushpop_count", DW'(wb_count_o), DW'(5));

    // Reset with two entries pending and a saturated counter
    drive(1'b1, 6'd12, {NLANES{32'h0C0C0C0C}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    step();
    in_valid_i = 1'b0;
    force dut.wb_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_reg;
    #1;
    check("preset_count", DW'(wb_count_o), DW'(32'hFFFF_FFFF));
    rst = 1'b1;
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    step();
    rst = 1'b0;
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    check("rst2_valid", DW'(wb_valid_o), DW'(0));
    check("rst2_count", DW'(wb_count_o), DW'(0));
    check("rst2_ready", DW'(in_ready_o), DW'(1));

    // Counter wrap on a pop
    drive(1'b1, 6'd13, {NLANES{32'h0D0D0D0D}}, '0, 16'hFFFF, 1'b0, 1'b0);
    step();
    in_valid_i = 1'b0;
    force dut.wb_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_reg;
    #1;
    check("wrap_pre", DW'(wb_count_o), DW'(32'hFFFF_FFFF));
    wb_ready_i = 1'b1;
    step();
    wb_ready_i = 1'b0;
    check("wrap_count", DW'(wb_count_o), DW'(0));
    check("wrap_valid", DW'(wb_valid_o), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rfphoenix_vec_wb.md
RFPHOENIX_VEC_WB -- requirements
Module: rfphoenix_vec_wb

Interface
REQ-001 SHALL have parameter NLANES, default 16, number of 32-bit vector lanes.
REQ-002 SHALL have parameter DEPTH, default 2, number of result buffer entries; legal values 2 and 4.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, discards all buffered results.
REQ-006 SHALL have port in_valid_i, input, 1, result from the vector ALU is present.
REQ-007 SHALL have port in_ready_o, output, 1, buffer can accept a result this cycle.
REQ-008 SHALL have port res_i, input, NLANES*32, vector ALU output.
REQ-009 SHALL have port t_i, input, NLANES*32, prior target register value.
REQ-010 SHALL have port mask_i, input, NLANES, per-lane write mask.
REQ-011 SHALL have port zm_i, input, 1, zeroing merge: masked-off lanes become 0, not t_i.
REQ-012 SHALL have port scalar_i, input, 1, scalar target: only lane 0 is written.
REQ-013 SHALL have port rd_i, input, 6, target register number.
REQ-014 SHALL have port wb_valid_o, wb_ready_i, wb_rd_o, wb_data_o (NLANES*32) and wb_we_o (NLANES): register-file write port.
REQ-015 SHALL have port wb_count_o, output, 32, count of completed writebacks.
REQ-016 SHALL have ports byp_valid_o (1), byp_rd_o (6) and byp_data_o (NLANES*32), outputs, operand bypass.

Function
REQ-017 SHALL accept an entry when in_valid_i and in_ready_o are both high on a clock edge.
REQ-018 SHALL compute the merge at accept time, per lane n: mask_i[n] ? res_i[n] : (zm_i ? 0 : t_i[n]).
REQ-019 SHALL, when scalar_i=1, ignore mask_i, store res_i lane 0 and zero lanes 1..NLANES-1, and set we = 1 for lane 0 only.
REQ-020 SHALL, when scalar_i=0, set we to all ones.
REQ-021 SHALL store each entry as {rd, merged data, we} in a circular FIFO with rd_ptr, wr_ptr and count.
REQ-022 SHALL drive in_ready_o = (count < DEPTH), a combinational function of registered state only.
REQ-023 SHALL drive wb_valid_o = (count != 0) and present the head entry on wb_rd_o, wb_data_o and wb_we_o.
REQ-024 SHALL pop the head entry when wb_valid_o and wb_ready_i are both high.
REQ-025 SHALL have a latency of 1 cycle: an entry accepted at edge k appears on wb_valid_o after edge k, provided the buffer was empty.
REQ-026 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-027 SHALL, when full, still pop in that cycle, but in_ready_o is low so no push occurs.
REQ-028 SHALL wrap pointers modulo DEPTH.
REQ-029 SHALL hold the head entry stable while wb_valid_o=1 and wb_ready_i=0.
REQ-030 SHALL, on flush_i=1, set count, rd_ptr and wr_ptr to 0 at that edge, ignoring any push or pop in the same cycle.
REQ-031 SHALL not increment wb_count_o on a flushed pop.
REQ-032 SHALL increment wb_count_o by 1 on each pop and wrap from FFFFFFFF to 0.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, clear count, both pointers and wb_count_o to 0.
REQ-034 SHALL, after reset, hold wb_valid_o=0, byp_valid_o=0 and in_ready_o=1.
REQ-035 SHALL give rst priority over flush_i and over all handshakes, including a reset mid-stall that discards pending entries.
REQ-036 SHALL not reset entry storage.

Configuration
REQ-037 SHALL, with macro RFPHOENIX_VEC_WB_BYPASS_EN defined, drive byp_valid_o = wb_valid_o, byp_rd_o = head rd and byp_data_o = head data.
REQ-038 SHALL, without RFPHOENIX_VEC_WB_BYPASS_EN, keep the bypass ports present and tie them constant 0, with no bypass logic synthesized.

Verification
REQ-039 SHALL cover: NLANES=16, mask_i=0x00FF, zm_i=0, res lanes all 0x11111111, t lanes all 0x22222222 -> next cycle wb_data_o lanes 0-7 = 0x11111111, lanes 8-15 = 0x22222222, wb_we_o = 0xFFFF.
REQ-040 SHALL cover: the same input with zm_i=1 -> lanes 8-15 = 0, and wb_count_o = 1 after the pop.
REQ-041 SHALL cover: scalar_i=1, res lane 0 = 0x0000ABCD, mask_i=0 -> wb_we_o = 0x0001, lane 0 = 0x0000ABCD, other lanes 0.
REQ-042 SHALL cover: wb_ready_i=0 while pushing 3 results with DEPTH=2 -> in_ready_o low after the 2nd accept, third held upstream; then wb_ready_i=1 -> pops in order rd 1, 2, 3.
REQ-043 SHALL cover: count=2 with flush_i=1 and in_valid_i=1 in the same cycle -> next cycle wb_valid_o=0, in_ready_o=1, wb_count_o unchanged.
REQ-044 SHALL cover: rst asserted with 2 entries pending and wb_count_o=0xFFFFFFFF -> next cycle wb_valid_o=0 and wb_count_o=0; separately, a pop at count 0xFFFFFFFF -> wb_count_o wraps to 0.
